// File: rtl/pipe_boot_pkg.sv
// Shared state encoding and register-preload modes for the pipeline boot controller.
package pipe_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } boot_state_e;

    localparam int INIT_NONE  = 0;
    localparam int INIT_INDEX = 1;
    localparam int INIT_ZERO  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_boot_dump.sv
// Dump read stage: the register file answers one cycle after rf_addr, so the
// returned word is presented directly and parked in a skid register on a stall.
module pipe_boot_dump #(
    parameter int DATA_W = 32,
    parameter int RW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic [RW-1:0]     idx_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              d_ready_i,
    output logic              d_valid_o,
    output logic [DATA_W-1:0] d_data_o,
    output logic [RW-1:0]     d_index_o,
    output logic              can_issue_o
);
    logic              pend_q;
    logic [RW-1:0]     pend_idx_q;
    logic              skid_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [RW-1:0]     skid_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            skid_q      <= 1'b0;
            skid_data_q <= '0;
            skid_idx_q  <= '0;
        end else begin
            pend_q <= issue_i;
            if (issue_i) pend_idx_q <= idx_i;
            // Read data is only on rdata_i for one cycle; capture it if not taken.
            if (skid_q && d_ready_i) begin
                skid_q <= 1'b0;
            end else if (pend_q && !skid_q && !d_ready_i) begin
                skid_q      <= 1'b1;
                skid_data_q <= rdata_i;
                skid_idx_q  <= pend_idx_q;
            end
        end
    end

    always_comb begin
        d_valid_o = skid_q | pend_q;
        d_data_o  = '0;
        d_index_o = '0;
        if (skid_q) begin
            d_data_o  = skid_data_q;
            d_index_o = skid_idx_q;
        end else if (pend_q) begin
            d_data_o  = rdata_i;
            d_index_o = pend_idx_q;
        end
    end

    // At most one word is ever in flight or parked, so a new read may go out
    // whenever the presented word (if any) leaves this cycle.
    assign can_issue_o = !d_valid_o || d_ready_i;

endmodule

// File: rtl/pipe_boot_ctrl.sv
// Boot sequencer: preload registers, stream program into imem, run the core
// under a watchdog, then stream out the first DUMP_REGS registers.
module pipe_boot_ctrl
    import pipe_boot_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int NUM_REGS   = 32,
    parameter int DUMP_REGS  = 11,
    parameter int INIT_MODE  = 1,
    parameter int MAX_CYCLES = 1000,
    localparam int RW        = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rf_we,
    output logic [RW-1:0]     rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              core_rst_n,
    input  logic              core_halted,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [DATA_W-1:0] d_data,
    output logic [RW-1:0]     d_index,
    output logic              done,
    output logic              timeout
);
    // One counter serves INIT index, RUN cycle count and DUMP read index.
    localparam int CW = $clog2(max_int(MAX_CYCLES, NUM_REGS + 1) + 1);

    boot_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              timeout_q, timeout_d;
    logic              dump_issue;
    logic              dump_ok;
    logic              last_dump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            timeout_q <= timeout_d;
        end
    end

    pipe_boot_dump #(
        .DATA_W (DATA_W),
        .RW     (RW)
    ) u_dump (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (dump_issue),
        .idx_i       (cnt_q[RW-1:0]),
        .rdata_i     (rf_rdata),
        .d_ready_i   (d_ready),
        .d_valid_o   (d_valid),
        .d_data_o    (d_data),
        .d_index_o   (d_index),
        .can_issue_o (dump_ok)
    );

    assign last_dump = d_valid && d_ready && (d_index == RW'(DUMP_REGS - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        timeout_d  = timeout_q;
        s_ready    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_wdata   = '0;
        dump_issue = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = (INIT_MODE == INIT_NONE) ? ST_LOAD : ST_INIT;
                    cnt_d     = '0;
                    addr_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_INIT: begin
                rf_we    = 1'b1;
                rf_addr  = cnt_q[RW-1:0];
                rf_wdata = (INIT_MODE == INIT_INDEX) ? DATA_W'(cnt_q[RW-1:0]) : '0;
                if (cnt_q == CW'(NUM_REGS - 1)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOAD: begin
                s_ready  = 1'b1;
                mem_addr = addr_q;
                if (s_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = s_data;
                    addr_d    = addr_q + ADDR_W'(1);
                    // Top address accepted: leave rather than wrap over word 0.
                    if (s_last || (addr_q == '1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (core_halted) begin
                    state_d = ST_DUMP;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(MAX_CYCLES - 1)) begin
                    state_d   = ST_DUMP;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DUMP: begin
                rf_addr = cnt_q[RW-1:0];
                if (dump_ok && (cnt_q < CW'(DUMP_REGS))) begin
                    dump_issue = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                end
                if (last_dump) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign core_rst_n = (state_q == ST_RUN) || (state_q == ST_DUMP) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pipe_boot_ctrl.sv
// Directed boot sequences with randomized handshakes and core register writes,
// checked against a register-file / program model kept in the bench.
module tb_pipe_boot_ctrl;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 4;
    localparam int NUM_REGS   = 32;
    localparam int RW         = 5;
    localparam int DUMP_REGS  = 11;
    localparam int INIT_MODE  = 1;
    localparam int MAX_CYCLES = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rf_we;
    logic [RW-1:0]     rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata = '0;
    logic              core_rst_n;
    logic              core_halted = 1'b0;
    logic              d_valid;
    logic              d_ready = 1'b0;
    logic [DATA_W-1:0] d_data;
    logic [RW-1:0]     d_index;
    logic              done;
    logic              timeout;

    logic              cw_en = 1'b0;
    logic [RW-1:0]     cw_addr = '0;
    logic [DATA_W-1:0] cw_data = '0;
    logic [DATA_W-1:0] rf_mem [NUM_REGS];
    logic [DATA_W-1:0] exp_rf [NUM_REGS];
    logic [DATA_W-1:0] words [16];
    logic              exp_to = 1'b0;
    int                n_chk = 0;
    int                n_fail = 0;

    pipe_boot_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .DUMP_REGS(DUMP_REGS),
        .INIT_MODE(INIT_MODE), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .core_rst_n(core_rst_n), .core_halted(core_halted),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_index(d_index),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Register file: boot writes, core writes while running, one-cycle read.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr] <= rf_wdata;
        else if (cw_en) rf_mem[cw_addr] <= cw_data;
        rf_rdata <= rf_mem[rf_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, 64'({mem_we, rf_we, core_rst_n, s_ready, d_valid, done, timeout}), 64'd0);
        chk({tag, ".bus"}, 64'({mem_addr, rf_addr, d_index}), 64'd0);
        chk({tag, ".data"}, 64'(mem_wdata | rf_wdata | d_data), 64'd0);
    endtask

    task automatic do_start();
        cycle();
        start       = 1'b1;
        core_halted = 1'b0;
    endtask

    task automatic do_init();
        for (int k = 0; k < NUM_REGS; k++) begin
            cycle();
            start = 1'b0;
            #1;
            if (k == 0) chk("init.clr", 64'({done, timeout}), 64'd0);
            exp_rf[k] = DATA_W'(k);
            chk("init.wr", 64'({rf_we, rf_addr, rf_wdata, core_rst_n, s_ready}),
                64'({1'b1, RW'(k), exp_rf[k], 1'b0, 1'b0}));
        end
    endtask

    task automatic do_load(input int nwords, input bit use_last, input int start_glitch);
        int idx = 0;
        int guard = 0;
        while (idx < nwords && guard < 200) begin
            cycle();
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = words[idx];
            s_last  = use_last && (idx == nwords - 1);
            start   = (guard == start_glitch);
            #1;
            if (s_valid)
                chk("load.wr", 64'({s_ready, mem_we, mem_addr, mem_wdata}),
                    64'({1'b1, 1'b1, ADDR_W'(idx), words[idx]}));
            else
                chk("load.idle", 64'({s_ready, mem_we, mem_addr}), 64'({1'b1, 1'b0, ADDR_W'(idx)}));
            if (s_valid) idx++;
            guard++;
        end
        chk("load.bound", 64'(idx), 64'(nwords));
    endtask

    task automatic do_run(input int halt_at);
        int c_end;
        c_end  = (halt_at < MAX_CYCLES - 1) ? halt_at : MAX_CYCLES - 1;
        exp_to = (halt_at > MAX_CYCLES - 1);
        for (int c = 0; c <= c_end; c++) begin
            cycle();
            start       = 1'b0;
            s_last      = 1'b0;
            s_valid     = 1'($urandom_range(0, 1));
            cw_en       = 1'b1;
            cw_addr     = RW'($urandom_range(0, NUM_REGS - 1));
            cw_data     = $urandom();
            exp_rf[cw_addr] = cw_data;
            core_halted = (c >= halt_at);
            #1;
            chk("run.ctl", 64'({core_rst_n, s_ready, mem_we, rf_we, d_valid, timeout}), 64'(6'b100000));
        end
    endtask

    task automatic do_dump(input bit stall3, input bit all_ready);
        int exp_idx = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        int stalled = 0;
        bit prev_stall = 1'b0;
        logic [RW-1:0] prev_i = '0;
        logic [DATA_W-1:0] prev_d = '0;
        cycle();
        cw_en   = 1'b0;
        s_valid = 1'b0;
        d_ready = 1'b0;
        #1;
        chk("dump.entry", 64'({timeout, d_valid, rf_addr}), 64'({exp_to, 1'b0, RW'(0)}));
        while (exp_idx < DUMP_REGS && cyc < 300) begin
            cycle();
            cyc++;
            if (prev_stall)
                chk("dump.hold", 64'({d_valid, d_index, d_data}), 64'({1'b1, prev_i, prev_d}));
            if (d_valid) begin
                if (first < 0) first = cyc;
                if (stall3 && d_index == RW'(3) && stalled < 5) begin
                    d_ready = 1'b0;
                    stalled++;
                end else begin
                    d_ready = all_ready ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                end
                #1;
                if (d_ready) begin
                    chk("dump.word", 64'({d_index, d_data}), 64'({RW'(exp_idx), exp_rf[exp_idx]}));
                    exp_idx++;
                    last = cyc;
                end
                prev_stall = !d_ready;
                prev_i     = d_index;
                prev_d     = d_data;
            end else begin
                d_ready    = 1'($urandom_range(0, 1));
                prev_stall = 1'b0;
            end
        end
        chk("dump.bound", 64'(exp_idx), 64'(DUMP_REGS));
        chk("dump.lat", 64'(first), 64'(1));
        if (all_ready) chk("dump.thru", 64'(last - first + 1), 64'(DUMP_REGS));
        if (stall3) chk("dump.stall", 64'(stalled), 64'(5));
    endtask

    task automatic do_done();
        cycle();
        d_ready = 1'b0;
        #1;
        chk("done.set", 64'({done, timeout, d_valid, core_rst_n}), 64'({1'b1, exp_to, 1'b0, 1'b1}));
        cycle();
        chk("done.hold", 64'({done, timeout}), 64'({1'b1, exp_to}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) cycle();
        chk_all_zero("reset");
        rst_n = 1'b1;
        cycle();
        chk_all_zero("idle");

        // Halt at RUN cycle 40, dump with a 5-cycle stall at index 3.
        for (int i = 0; i < 16; i++) words[i] = $urandom();
        words[10] = 32'hfc000000;
        do_start();
        do_init();
        do_load(11, 1'b1, 3);
        do_run(40);
        do_dump(1'b1, 1'b0);
        do_done();

        // Restart from DONE, fill to the top address, watchdog expiry.
        for (int i = 0; i < 16; i++) words[i] = $urandom();
        do_start();
        do_init();
        do_load(16, 1'b0, -1);
        do_run(1000);
        do_dump(1'b0, 1'b1);
        do_done();

        // Abort during LOAD, then a clean rerun where halt meets the limit.
        do_start();
        do_init();
        for (int i = 0; i < 4; i++) begin
            cycle();
            s_valid = 1'b1;
            s_data  = words[i];
            s_last  = 1'b0;
            #1;
            chk("abort.wr", 64'({mem_we, mem_addr}), 64'({1'b1, ADDR_W'(i)}));
        end
        cycle();
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        cycle();
        chk_all_zero("abort.hold");
        rst_n   = 1'b1;
        s_valid = 1'b0;
        do_start();
        do_init();
        do_load(5, 1'b1, -1);
        do_run(MAX_CYCLES - 1);
        do_dump(1'b0, 1'b0);
        do_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
